// File: rtl/buffer_burst_reader_pkg.sv
// Shared definitions for the buffer burst reader: FSM state encoding and default geometry.
package buffer_burst_reader_pkg;

  // Default frame geometry
  localparam int unsigned DEFAULT_DEPTH = 8;
  localparam int unsigned DEFAULT_WIDTH = 4;

  // Fill/drain FSM state encoding (binary)
  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

endpackage : buffer_burst_reader_pkg

// File: rtl/buffer_burst_reader.sv
// Captures a frame of DEPTH words (one per accepted beat) into an internal array, then
// drains it in index order over a valid/ready stream with a last marker. One frame in flight.
//
// Ports:
//   clk        in   1      clock, all state on posedge
//   rstn       in   1      asynchronous active-low reset
//   enable     in   1      fill side may accept words (does not gate drain)
//   in_valid   in   1      producer word valid
//   in_data    in   WIDTH  producer word
//   in_ready   out  1      word accepted this cycle when in_valid is high
//   out_valid  out  1      out_data valid
//   out_data   out  WIDTH  buffer[rd_ptr]
//   out_last   out  1      current beat is entry DEPTH-1
//   out_ready  in   1      consumer accepts beat
//   frame_cnt  out  8      completed (fully drained) frames, wraps 255->0
module buffer_burst_reader
  import buffer_burst_reader_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic [7:0]       frame_cnt
);

  localparam int unsigned        PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0]   LAST_IDX = PTR_W'(DEPTH - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [WIDTH-1:0] r_buf [DEPTH];
  logic [7:0]       r_frame_cnt;
  logic             w_wr_en;
  logic             w_rd_en;

  // Handshake qualifiers; in_ready is already low in DRAIN so no write can slip in
  assign w_wr_en   = in_valid && in_ready;
  assign w_rd_en   = out_valid && out_ready;
  assign frame_cnt = r_frame_cnt;

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: switch after the last write / last transferred beat
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL: begin
        if (w_wr_en && (r_wr_ptr == LAST_IDX)) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_rd_en && out_last) begin
          w_state_nxt = ST_FILL;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  // FSM outputs: stream outputs depend only on registered state/pointer, never on out_ready
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (r_state)
      ST_FILL: begin
        in_ready = enable;
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        out_data  = r_buf[r_rd_ptr];
        out_last  = (r_rd_ptr == LAST_IDX);
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Datapath: buffer array, pointers and frame counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_frame_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      if (w_wr_en) begin
        r_buf[r_wr_ptr] <= in_data;
        r_wr_ptr        <= (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_rd_en) begin
        if (r_rd_ptr == LAST_IDX) begin
          r_rd_ptr    <= '0;
          r_frame_cnt <= r_frame_cnt + 8'(1);
        end else begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
      end
    end
  end

endmodule : buffer_burst_reader
